rfg_counter_bank: RTL and testbench

RFG_COUNTER_BANK -- requirements
Module: rfg_counter_bank

---
 rtl/rfg_counter_pkg.sv | 23 ++
 rtl/rfg_counter_bank_if.sv | 46 ++++
 rtl/rfg_counter_lane.sv | 101 ++++++++++
 rtl/rfg_counter_bank.sv | 118 +++++++++++
 tb/tb_rfg_counter_bank.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rfg_counter_pkg.sv
// -----------------------------------------------------------------------------
// rfg_counter_pkg
// Shared constants and helpers for the rfg_counter_bank block.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   selWidth()           : width of a lane-select field for a given lane count
// No ports (package).
// -----------------------------------------------------------------------------
package rfg_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // A select field is never narrower than one bit, even for a single lane.
    function automatic int selWidth(input int channels);
        int w;
        w = $clog2(channels);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rfg_counter_bank_if.sv
// -----------------------------------------------------------------------------
// rfg_counter_bank_if
// Bundles the request/response signals of rfg_counter_bank.
// Parameters CHANNELS, DATASIZE, STEPSIZE must match the attached bank.
//   increment      : per-lane increment request
//   step           : per-lane step, lane i at [i*STEPSIZE +: STEPSIZE]
//   load_enable    : load request for lane load_sel
//   load_sel       : target lane of a load
//   load           : load value
//   overflow_clear : per-lane sticky-flag clear strobe
//   value          : lane counts, lane i at [i*DATASIZE +: DATASIZE]
//   overflow       : per-lane sticky overflow flag
//   irq            : registered OR of overflow
// master = requester side, slave = counter bank side.
// -----------------------------------------------------------------------------
interface rfg_counter_bank_if
    import rfg_counter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DATASIZE = 48,
    parameter int STEPSIZE = 1
);

    localparam int SELW = selWidth(CHANNELS);

    logic [CHANNELS-1:0]          increment;
    logic [CHANNELS*STEPSIZE-1:0] step;
    logic                         load_enable;
    logic [SELW-1:0]              load_sel;
    logic [DATASIZE-1:0]          load;
    logic [CHANNELS-1:0]          overflow_clear;
    logic [CHANNELS*DATASIZE-1:0] value;
    logic [CHANNELS-1:0]          overflow;
    logic                         irq;

    modport master (
        output increment, step, load_enable, load_sel, load, overflow_clear,
        input  value, overflow, irq
    );

    modport slave (
        input  increment, step, load_enable, load_sel, load, overflow_clear,
        output value, overflow, irq
    );

endinterface

// File: rtl/rfg_counter_lane.sv
// -----------------------------------------------------------------------------
// rfg_counter_lane
// One counter lane: load mux, step add, wrap or saturate, sticky overflow.
// Optional feature macro: RFG_COUNTER_OVERFLOW_EN (sticky flag present when
// defined, otherwise overflow_o is tied low and overflowClear_i is unused).
//   clk             : rising-edge clock
//   res             : synchronous active-high reset
//   increment_i     : add step_i this edge
//   step_i          : unsigned step
//   loadHit_i       : registered load targets this lane
//   loadValue_i     : registered load value
//   overflowClear_i : clear the sticky flag
//   value_o         : lane count (straight from the register)
//   overflow_o      : sticky overflow flag
// -----------------------------------------------------------------------------
module rfg_counter_lane
    import rfg_counter_pkg::*;
#(
    parameter int DATASIZE = 48,
    parameter int STEPSIZE = 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                clk,
    input  logic                res,
    input  logic                increment_i,
    input  logic [STEPSIZE-1:0] step_i,
    input  logic                loadHit_i,
    input  logic [DATASIZE-1:0] loadValue_i,
    input  logic                overflowClear_i,
    output logic [DATASIZE-1:0] value_o,
    output logic                overflow_o
);

    logic [DATASIZE-1:0] value_q;
    logic [DATASIZE-1:0] value_d;
    logic [DATASIZE-1:0] base;
    logic [DATASIZE:0]   stepExt;
    logic [DATASIZE:0]   sum;
    logic                carry;

    // The sum is one bit wider than the lane so the carry falls out as the
    // top bit. A load replaces the current count as the base of the add, so
    // load and increment in the same edge give load + step. With no
    // increment the step contributes zero, which also covers plain hold and
    // plain load; a zero step can never produce a carry.
    always_comb begin
        stepExt = '0;
        if (increment_i) begin
            stepExt[STEPSIZE-1:0] = step_i;
        end
        base    = loadHit_i ? loadValue_i : value_q;
        sum     = {1'b0, base} + stepExt;
        carry   = sum[DATASIZE];
        value_d = sum[DATASIZE-1:0];
        if (carry && (SATURATE == MODE_SAT)) begin
            value_d = '1;
        end
    end

    // Lane count register; the output is taken directly from it.
    always_ff @(posedge clk) begin
        if (res) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

`ifdef RFG_COUNTER_OVERFLOW_EN
    logic overflow_q;
    logic overflow_d;

    // Clear is applied first so that a carry in the same edge wins.
    always_comb begin
        overflow_d = overflow_q;
        if (overflowClear_i) begin
            overflow_d = 1'b0;
        end
        if (carry) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;
`else
    logic unusedClear;
    assign unusedClear = overflowClear_i;
    assign overflow_o  = 1'b0;
`endif

endmodule

// File: rtl/rfg_counter_bank.sv
// -----------------------------------------------------------------------------
// rfg_counter_bank
// Bank of CHANNELS independent counters with per-lane step, a shared
// registered load path, wrap/saturate mode and sticky overflow flags.
// Optional feature macro: RFG_COUNTER_OVERFLOW_EN (overflow flags, clear and
// irq active when defined; tied low otherwise).
//   clk : rising-edge clock
//   res : synchronous active-high reset
//   bus : rfg_counter_bank_if.slave (increment, step, load_enable, load_sel,
//         load, overflow_clear in; value, overflow, irq out). The interface
//         must be built with the same CHANNELS/DATASIZE/STEPSIZE.
// -----------------------------------------------------------------------------
module rfg_counter_bank
    import rfg_counter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DATASIZE = 48,
    parameter int STEPSIZE = 1,
    parameter int SATURATE = MODE_WRAP,
    parameter int LOADABLE = 1
) (
    input  logic              clk,
    input  logic              res,
    rfg_counter_bank_if.slave bus
);

    localparam int SELW = selWidth(CHANNELS);

    logic [CHANNELS-1:0]          loadHit;
    logic [DATASIZE-1:0]          loadValue;
    logic [CHANNELS*DATASIZE-1:0] laneValue;
    logic [CHANNELS-1:0]          laneOverflow;

    generate
        if (LOADABLE != 0) begin : gLoad
            logic                loadEnable_q;
            logic [SELW-1:0]     loadSel_q;
            logic [DATASIZE-1:0] load_q;

            // Load request is pipelined one stage before it reaches a lane.
            // Resetting these stages is what drops a load that was in flight
            // when reset arrived.
            always_ff @(posedge clk) begin
                if (res) begin
                    loadEnable_q <= 1'b0;
                    loadSel_q    <= '0;
                    load_q       <= '0;
                end else begin
                    loadEnable_q <= bus.load_enable;
                    loadSel_q    <= bus.load_sel;
                    load_q       <= bus.load;
                end
            end

            // A select at or beyond CHANNELS matches no lane, so such a load
            // simply vanishes.
            always_comb begin
                loadHit = '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (loadEnable_q && (loadSel_q == SELW'(i))) begin
                        loadHit[i] = 1'b1;
                    end
                end
            end

            assign loadValue = load_q;
        end else begin : gNoLoad
            logic unusedLoad;
            assign unusedLoad = ^{bus.load_enable, bus.load_sel, bus.load};
            assign loadHit    = '0;
            assign loadValue  = '0;
        end
    endgenerate

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : gLane
            rfg_counter_lane #(
                .DATASIZE (DATASIZE),
                .STEPSIZE (STEPSIZE),
                .SATURATE (SATURATE)
            ) uLane (
                .clk             (clk),
                .res             (res),
                .increment_i     (bus.increment[g]),
                .step_i          (bus.step[g*STEPSIZE +: STEPSIZE]),
                .loadHit_i       (loadHit[g]),
                .loadValue_i     (loadValue),
                .overflowClear_i (bus.overflow_clear[g]),
                .value_o         (laneValue[g*DATASIZE +: DATASIZE]),
                .overflow_o      (laneOverflow[g])
            );
        end
    endgenerate

    assign bus.value    = laneValue;
    assign bus.overflow = laneOverflow;

`ifdef RFG_COUNTER_OVERFLOW_EN
    logic irq_q;
    logic irq_d;

    // Interrupt is a registered summary, so it trails the flags by one edge.
    assign irq_d = |laneOverflow;

    always_ff @(posedge clk) begin
        if (res) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_rfg_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_rfg_counter_bank
// Directed-vector bench for rfg_counter_bank using three instances:
//   dutA : 4 lanes x 8 bits, 4-bit steps, wrap
//   dutB : 2 lanes x 8 bits, 4-bit steps, saturate
//   dutC : 3 lanes x 16 bits, 2-bit steps, wrap
// Expected overflow/irq values follow RFG_COUNTER_OVERFLOW_EN.
// -----------------------------------------------------------------------------
module tb_rfg_counter_bank;

    import rfg_counter_pkg::*;

`ifdef RFG_COUNTER_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic clk;
    logic res;
    int   vectorCount;
    int   miscompareCount;

    rfg_counter_bank_if #(.CHANNELS(4), .DATASIZE(8),  .STEPSIZE(4)) ifA ();
    rfg_counter_bank_if #(.CHANNELS(2), .DATASIZE(8),  .STEPSIZE(4)) ifB ();
    rfg_counter_bank_if #(.CHANNELS(3), .DATASIZE(16), .STEPSIZE(2)) ifC ();

    rfg_counter_bank #(
        .CHANNELS(4), .DATASIZE(8), .STEPSIZE(4), .SATURATE(MODE_WRAP), .LOADABLE(1)
    ) dutA (
        .clk (clk),
        .res (res),
        .bus (ifA)
    );

    rfg_counter_bank #(
        .CHANNELS(2), .DATASIZE(8), .STEPSIZE(4), .SATURATE(MODE_SAT), .LOADABLE(1)
    ) dutB (
        .clk (clk),
        .res (res),
        .bus (ifB)
    );

    rfg_counter_bank #(
        .CHANNELS(3), .DATASIZE(16), .STEPSIZE(2), .SATURATE(MODE_WRAP), .LOADABLE(1)
    ) dutC (
        .clk (clk),
        .res (res),
        .bus (ifC)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the given number of edges and settle just after the last one.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts the vector and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Directed sequence; every expected value below is worked out by hand.
    initial begin
        vectorCount     = 0;
        miscompareCount = 0;
        res             = 1'b1;

        ifA.increment = '0; ifA.step = '0; ifA.load_enable = 1'b0;
        ifA.load_sel  = '0; ifA.load = '0; ifA.overflow_clear = '0;
        ifB.increment = '0; ifB.step = '0; ifB.load_enable = 1'b0;
        ifB.load_sel  = '0; ifB.load = '0; ifB.overflow_clear = '0;
        ifC.increment = '0; ifC.step = '0; ifC.load_enable = 1'b0;
        ifC.load_sel  = '0; ifC.load = '0; ifC.overflow_clear = '0;

        applyStimulus(2);
        checkOutput("rst_A_value",    64'(ifA.value),    64'h0);
        checkOutput("rst_A_overflow", 64'(ifA.overflow), 64'h0);
        checkOutput("rst_A_irq",      64'(ifA.irq),      64'h0);
        checkOutput("rst_B_value",    64'(ifB.value),    64'h0);
        checkOutput("rst_C_value",    64'(ifC.value),    64'h0);
        res = 1'b0;

        // dutA: load FE into lane0, then FE + 3 wraps to 01 with overflow.
        ifA.load_enable = 1'b1; ifA.load_sel = 2'd0; ifA.load = 8'hFE;
        applyStimulus(1);
        checkOutput("A_load_not_yet", 64'(ifA.value), 64'h0000_0000);
        ifA.load_enable = 1'b0;
        applyStimulus(1);
        checkOutput("A_load_landed", 64'(ifA.value), 64'h0000_00FE);
        ifA.increment = 4'b0001; ifA.step = 16'h0003;
        applyStimulus(1);
        checkOutput("A_wrap_value",    64'(ifA.value),    64'h0000_0001);
        checkOutput("A_wrap_overflow", 64'(ifA.overflow), 64'({3'b000, OVF_EN}));
        checkOutput("A_irq_lag",       64'(ifA.irq),      64'h0);
        ifA.increment = 4'b0000;
        applyStimulus(1);
        checkOutput("A_irq_set",  64'(ifA.irq),   64'(OVF_EN));
        checkOutput("A_hold",     64'(ifA.value), 64'h0000_0001);

        // dutA: several lanes at once, lane2 with step 0 holds and stays clean.
        ifA.increment = 4'b1110; ifA.step = 16'hF070;
        applyStimulus(2);
        checkOutput("A_multi_value",    64'(ifA.value),    64'h1E00_0E01);
        checkOutput("A_multi_overflow", 64'(ifA.overflow), 64'({3'b000, OVF_EN}));
        ifA.increment = 4'b0000; ifA.step = 16'h0000;

        // dutA: load FF into lane0; the load leaves the sticky flag alone.
        ifA.load_enable = 1'b1; ifA.load_sel = 2'd0; ifA.load = 8'hFF;
        applyStimulus(1);
        ifA.load_enable = 1'b0;
        applyStimulus(1);
        checkOutput("A_load_ff",        64'(ifA.value),    64'h1E00_0EFF);
        checkOutput("A_load_keeps_ovf", 64'(ifA.overflow), 64'({3'b000, OVF_EN}));

        // dutA: clear collides with a new carry on lane0, carry wins.
        ifA.increment = 4'b0001; ifA.step = 16'h0001; ifA.overflow_clear = 4'b0001;
        applyStimulus(1);
        checkOutput("A_clr_vs_carry_value", 64'(ifA.value),    64'h1E00_0E00);
        checkOutput("A_clr_vs_carry_ovf",   64'(ifA.overflow), 64'({3'b000, OVF_EN}));
        ifA.increment = 4'b0000; ifA.step = 16'h0000;
        applyStimulus(1);
        checkOutput("A_clear_ovf",     64'(ifA.overflow), 64'h0);
        checkOutput("A_irq_still_set", 64'(ifA.irq),      64'(OVF_EN));
        ifA.overflow_clear = 4'b0000;
        applyStimulus(1);
        checkOutput("A_irq_cleared", 64'(ifA.irq), 64'h0);

        // dutA: load FA into lane3 plus step 9 in the landing cycle -> 03, carry.
        ifA.load_enable = 1'b1; ifA.load_sel = 2'd3; ifA.load = 8'hFA;
        applyStimulus(1);
        checkOutput("A_ld_inc_pending", 64'(ifA.value), 64'h1E00_0E00);
        ifA.load_enable = 1'b0; ifA.increment = 4'b1000; ifA.step = 16'h9000;
        applyStimulus(1);
        checkOutput("A_ld_inc_value",    64'(ifA.value),    64'h0300_0E00);
        checkOutput("A_ld_inc_overflow", 64'(ifA.overflow), 64'({OVF_EN, 3'b000}));
        ifA.increment = 4'b0000; ifA.step = 16'h0000;

        // dutB (saturate): lane1 FD + 5 clamps to FF and stays there.
        ifB.load_enable = 1'b1; ifB.load_sel = 1'b1; ifB.load = 8'hFD;
        applyStimulus(1);
        ifB.load_enable = 1'b0;
        applyStimulus(1);
        checkOutput("B_load_fd", 64'(ifB.value), 64'hFD00);
        ifB.increment = 2'b10; ifB.step = 8'h50;
        applyStimulus(1);
        checkOutput("B_sat_first",     64'(ifB.value),    64'hFF00);
        checkOutput("B_sat_first_ovf", 64'(ifB.overflow), 64'({OVF_EN, 1'b0}));
        ifB.increment = 2'b11; ifB.step = 8'h57;
        applyStimulus(1);
        checkOutput("B_sat_second",     64'(ifB.value),    64'hFF07);
        checkOutput("B_sat_second_ovf", 64'(ifB.overflow), 64'({OVF_EN, 1'b0}));
        ifB.increment = 2'b00; ifB.step = 8'h00;

        // dutC: load 1234 into lane2, increment by 1 in the landing cycle.
        ifC.load_enable = 1'b1; ifC.load_sel = 2'd2; ifC.load = 16'h1234;
        applyStimulus(1);
        checkOutput("C_load_pending", 64'(ifC.value), 64'h0);
        ifC.load_enable = 1'b0; ifC.increment = 3'b100; ifC.step = 6'b010000;
        applyStimulus(1);
        checkOutput("C_load_inc", 64'(ifC.value), 64'h1235_0000_0000);
        ifC.increment = 3'b000; ifC.step = 6'b000000;

        // dutC: load_sel 3 is out of range; lane0 still counts normally.
        ifC.load_enable = 1'b1; ifC.load_sel = 2'd3; ifC.load = 16'hBEEF;
        applyStimulus(1);
        ifC.load_enable = 1'b0; ifC.increment = 3'b001; ifC.step = 6'b000011;
        applyStimulus(1);
        checkOutput("C_bad_sel", 64'(ifC.value), 64'h1235_0000_0003);
        ifC.increment = 3'b000; ifC.step = 6'b000000;

        // Reset right after a load request, with increments also presented.
        ifC.load_enable = 1'b1; ifC.load_sel = 2'd1; ifC.load = 16'hAAAA;
        applyStimulus(1);
        ifC.load_enable = 1'b0; ifC.increment = 3'b111; ifC.step = 6'b111111;
        res = 1'b1;
        applyStimulus(1);
        checkOutput("C_reset_value",  64'(ifC.value),    64'h0);
        checkOutput("A_reset_value",  64'(ifA.value),    64'h0);
        checkOutput("A_reset_ovf",    64'(ifA.overflow), 64'h0);
        checkOutput("A_reset_irq",    64'(ifA.irq),      64'h0);
        checkOutput("B_reset_value",  64'(ifB.value),    64'h0);

        // First edge out of reset: increment acts now, new load lands next edge,
        // and the discarded AAAA load never shows up on lane1.
        res = 1'b0;
        ifC.increment = 3'b010; ifC.step = 6'b001000;
        ifC.load_enable = 1'b1; ifC.load_sel = 2'd0; ifC.load = 16'h0042;
        applyStimulus(1);
        checkOutput("C_post_reset_inc", 64'(ifC.value), 64'h0000_0002_0000);
        ifC.load_enable = 1'b0; ifC.increment = 3'b000; ifC.step = 6'b000000;
        applyStimulus(1);
        checkOutput("C_post_reset_load", 64'(ifC.value), 64'h0000_0002_0042);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
